// File: rtl/sobel_pkg.sv
// sobel_pkg: FSM state encoding, Sobel kernel coefficients and derived-width helpers
// latency: none (types and constants only)
// backpressure: none
package sobel_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQUEST = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } sobel_state_t;

  // Row 0 is the oldest line (top of the window), column 0 the oldest pixel (left).
  localparam int SOBEL_GX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  localparam int SOBEL_GY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

  function automatic int sobel_addr_w(input int w, input int h);
    return $clog2(w * h);
  endfunction

  function automatic int sobel_mag_w(input int px_w);
    return px_w + 3;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: circular shift line, dout is the sample written DEPTH shifts ago
// latency: DEPTH shift-enabled cycles from din to dout
// backpressure: none; holds contents and pointer while shift_en is low
module sobel_line_buffer #(
  parameter int DEPTH = 320,
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;

  // Read-before-write: the slot about to be overwritten holds the oldest sample.
  assign dout = mem[ptr];

  // Circular pointer advance on every shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (shift_en) begin
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

  // Storage is not reset; stale contents only ever reach border pixels.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/sobel_stream_engine.sv
// sobel_stream_engine: raster-order Sobel edge map, gray buffer in, edge buffer out; SOBEL_MAGNITUDE_OUT_EN selects scaled-magnitude output
// latency: write_en for centre k three cycles after read_addr k+IMG_W+1 (memory, window/magnitude, threshold register)
// backpressure: none once RUN starts; rq/ack arbitration only gates the start of a frame
module sobel_stream_engine
  import sobel_pkg::*;
#(
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int PX_W     = 15,
  parameter int THR_INIT = 22500,
  parameter int THR_STEP = 100,
  parameter int ADDR_W   = sobel_addr_w(IMG_W, IMG_H),
  parameter int MAG_W    = sobel_mag_w(PX_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              threshold_up,
  input  logic              threshold_down,
  input  logic              ack_read,
  output logic              rq_read,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [PX_W-1:0]   read_data,
  input  logic              ack_write,
  output logic              rq_write,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [PX_W-1:0]   write_data,
  output logic [MAG_W-1:0]  threshold_val,
  output logic              busy,
  output logic              frame_done
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int DR_W  = $clog2(IMG_W + 3);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] FIRST_TOK  = ADDR_W'(IMG_W + 1);
  // DRAIN issues IMG_W+1 tokens, then waits two cycles so DONE lines up with the last write.
  localparam logic [DR_W-1:0]   DRAIN_TOK  = DR_W'(IMG_W);
  localparam logic [DR_W-1:0]   DRAIN_END  = DR_W'(IMG_W + 2);
  localparam logic [MAG_W-1:0]  THR_MAX    = {MAG_W{1'b1}};
  localparam logic [MAG_W-1:0]  THR_STEP_M = MAG_W'(THR_STEP);

  sobel_state_t state, state_nxt;

  logic [ADDR_W-1:0] rd_addr;
  logic [DR_W-1:0]   drain_cnt;
  logic              tok0, tok1, tok2, in_vld;
  logic [PX_W-1:0]   lb0_dout, lb1_dout;
  logic [PX_W-1:0]   win_q [3][2];
  logic [PX_W-1:0]   win [3][3];
  logic signed [MAG_W-1:0] gx, gy;
  logic [MAG_W:0]    gx_abs, gy_abs, mag_sum;
  logic [MAG_W-1:0]  mag_d, mag_q, thr;
  logic [PX_W-1:0]   px_out;
  logic [ADDR_W-1:0] wr_addr_cnt;
  logic [COL_W-1:0]  wr_col;
  logic [ROW_W-1:0]  wr_row;
  logic              at_border;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; acks are only looked at before RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!ack_read && !ack_write) state_nxt = REQUEST;
      REQUEST: if (ack_read && ack_write)   state_nxt = RUN;
      RUN:     if (rd_addr == LAST_ADDR)    state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_END)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs and the stage-0 output token.
  always_comb begin
    rq_read    = (state == REQUEST) || (state == RUN) || (state == DRAIN);
    rq_write   = rq_read;
    busy       = rq_read;
    frame_done = (state == DONE);
    tok0       = ((state == RUN) && (rd_addr >= FIRST_TOK)) ||
                 ((state == DRAIN) && (drain_cnt <= DRAIN_TOK));
  end

  assign read_addr     = rd_addr;
  assign threshold_val = thr;

  // Raster read address and drain cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr   <= '0;
      drain_cnt <= '0;
    end else begin
      if (state == RUN) rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_W'(1);
      else              rd_addr <= '0;
      if (state == DRAIN) drain_cnt <= drain_cnt + DR_W'(1);
      else                drain_cnt <= '0;
    end
  end

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PX_W)) u_lb0 (
    .clk      (clk),
    .reset    (reset),
    .shift_en (in_vld),
    .din      (read_data),
    .dout     (lb0_dout)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PX_W)) u_lb1 (
    .clk      (clk),
    .reset    (reset),
    .shift_en (in_vld),
    .din      (lb0_dout),
    .dout     (lb1_dout)
  );

  // Window assembly (newest column straight from memory and line buffers) and |Gx|+|Gy|.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win[r][0] = win_q[r][0];
      win[r][1] = win_q[r][1];
    end
    win[0][2] = lb1_dout;
    win[1][2] = lb0_dout;
    win[2][2] = read_data;
    gx = '0;
    gy = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        gx = gx + MAG_W'(SOBEL_GX[r][c] * int'(win[r][c]));
        gy = gy + MAG_W'(SOBEL_GY[r][c] * int'(win[r][c]));
      end
    end
    // |G| <= 4*(2^PX_W-1) fits in MAG_W-1 bits, so negation cannot overflow.
    gx_abs  = {1'b0, gx[MAG_W-1] ? -gx : gx};
    gy_abs  = {1'b0, gy[MAG_W-1] ? -gy : gy};
    mag_sum = gx_abs + gy_abs;
    mag_d   = mag_sum[MAG_W] ? THR_MAX : mag_sum[MAG_W-1:0];
  end

  // Window columns shift once per valid pixel from memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= '0;
        win_q[r][1] <= '0;
      end
    end else if (in_vld) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win[r][2];
      end
    end
  end

  // Pipeline valids and the magnitude register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_vld <= 1'b0;
      tok1   <= 1'b0;
      tok2   <= 1'b0;
      mag_q  <= '0;
    end else begin
      in_vld <= (state == RUN);
      tok1   <= tok0;
      tok2   <= tok1;
      mag_q  <= mag_d;
    end
  end

  // Threshold: saturating step, simultaneous up and down cancel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thr <= MAG_W'(THR_INIT);
    end else if (threshold_up && !threshold_down) begin
      thr <= (thr > THR_MAX - THR_STEP_M) ? THR_MAX : thr + THR_STEP_M;
    end else if (threshold_down && !threshold_up) begin
      thr <= (thr < THR_STEP_M) ? '0 : thr - THR_STEP_M;
    end
  end

  assign at_border = (wr_row == '0) || (wr_row == ROW_W'(IMG_H - 1)) ||
                     (wr_col == '0) || (wr_col == COL_W'(IMG_W - 1));

  // Pixel value for a passing magnitude.
  always_comb begin
    px_out = '0;
    if (mag_q >= thr) begin
`ifdef SOBEL_MAGNITUDE_OUT_EN
      // MAG_W-3 == PX_W, so mag>>3 never exceeds the largest pixel value.
      px_out = mag_q[MAG_W-1:3];
`else
      px_out = '1;
`endif
    end
  end

  // Output register with write-side raster position for border masking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_en    <= 1'b0;
      write_addr  <= '0;
      write_data  <= '0;
      wr_addr_cnt <= '0;
      wr_col      <= '0;
      wr_row      <= '0;
    end else begin
      write_en <= tok2;
      if (tok2) begin
        write_addr  <= wr_addr_cnt;
        write_data  <= at_border ? '0 : px_out;
        wr_addr_cnt <= (wr_addr_cnt == LAST_ADDR) ? '0 : wr_addr_cnt + ADDR_W'(1);
        if (wr_col == COL_W'(IMG_W - 1)) begin
          wr_col <= '0;
          wr_row <= (wr_row == ROW_W'(IMG_H - 1)) ? '0 : wr_row + ROW_W'(1);
        end else begin
          wr_col <= wr_col + COL_W'(1);
        end
      end else if (state == IDLE) begin
        wr_addr_cnt <= '0;
        wr_col      <= '0;
        wr_row      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream_engine.sv
// tb_sobel_stream_engine: scoreboard bench for sobel_stream_engine on an 8x6 frame
// latency: n/a
// backpressure: n/a
module tb_sobel_stream_engine;

  localparam int W      = 8;
  localparam int H      = 6;
  localparam int NPIX   = W * H;
  localparam int PXW    = 15;
  localparam int MAGW   = 18;
  localparam int AW     = 6;
  localparam int PXMAX  = 32767;
  localparam int THRMAX = 262143;
  localparam int STEP   = 100;
  localparam int THR0   = 22500;

  typedef struct { int addr; int data; } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic threshold_up = 1'b0;
  logic threshold_down = 1'b0;
  logic ack_read = 1'b0;
  logic ack_write = 1'b0;
  logic rq_read, rq_write, write_en, busy, frame_done;
  logic [AW-1:0] read_addr, write_addr;
  logic [PXW-1:0] read_data, write_data;
  logic [MAGW-1:0] threshold_val;

  int   img [NPIX];
  exp_t exp_q [$];
  exp_t e;
  int   model_thr = THR0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;

  sobel_stream_engine #(.IMG_W(W), .IMG_H(H)) dut (
    .clk            (clk),
    .reset          (reset),
    .threshold_up   (threshold_up),
    .threshold_down (threshold_down),
    .ack_read       (ack_read),
    .rq_read        (rq_read),
    .read_addr      (read_addr),
    .read_data      (read_data),
    .ack_write      (ack_write),
    .rq_write       (rq_write),
    .write_en       (write_en),
    .write_addr     (write_addr),
    .write_data     (write_data),
    .threshold_val  (threshold_val),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  // Gray frame buffer: one-cycle registered read.
  always @(posedge clk) read_data <= PXW'(img[read_addr]);

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic int px(input int r, input int c);
    return img[r * W + c];
  endfunction

  // Reference: edge map of the whole frame from the image array and model threshold.
  task automatic push_expected();
    for (int k = 0; k < NPIX; k++) begin
      int r, c, gx, gy, mag, v;
      r = k / W;
      c = k % W;
      v = 0;
      if (r > 0 && r < H - 1 && c > 0 && c < W - 1) begin
        gx = (px(r-1, c+1) + 2 * px(r, c+1) + px(r+1, c+1)) -
             (px(r-1, c-1) + 2 * px(r, c-1) + px(r+1, c-1));
        gy = (px(r+1, c-1) + 2 * px(r+1, c) + px(r+1, c+1)) -
             (px(r-1, c-1) + 2 * px(r-1, c) + px(r-1, c+1));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mag > THRMAX) mag = THRMAX;
        if (mag >= model_thr) begin
`ifdef SOBEL_MAGNITUDE_OUT_EN
          v = (mag / 8 > PXMAX) ? PXMAX : mag / 8;
`else
          v = PXMAX;
`endif
        end
      end
      exp_q.push_back('{k, v});
    end
  endtask

  // Monitor: every write is popped against the scoreboard.
  always @(negedge clk) begin
    if (reset && write_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %0d with empty scoreboard", write_addr, write_data);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", write_addr, e.addr);
        check("write_data", write_data, e.data);
      end
    end
    if (reset && frame_done) begin
      done_cnt++;
      check("done_on_last_write", write_en ? write_addr : -1, NPIX - 1);
    end
  end

  task automatic thr_pulse(input bit up, input bit dn);
    threshold_up = up;
    threshold_down = dn;
    @(negedge clk);
    threshold_up = 1'b0;
    threshold_down = 1'b0;
    if (up && !dn) model_thr = (model_thr + STEP > THRMAX) ? THRMAX : model_thr + STEP;
    else if (dn && !up) model_thr = (model_thr < STEP) ? 0 : model_thr - STEP;
  endtask

  task automatic run_frame(input int hold);
    int i, c, d0, moved;
    ack_read = 1'b0;
    ack_write = 1'b0;
    wr_cnt = 0;
    d0 = done_cnt;
    push_expected();
    i = 0;
    while (!rq_read && i < 50) begin @(negedge clk); i++; end
    check("rq_read_raised", rq_read, 1);
    check("rq_write_raised", rq_write, 1);
    if (hold > 0) begin
      moved = 0;
      ack_write = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (read_addr != 0 || write_en || !rq_read) moved++;
      end
      check("stall_no_read_activity", moved, 0);
    end
    ack_read = 1'b1;
    ack_write = 1'b1;
    @(negedge clk);
    c = 0;
    while (!write_en && c < 200) begin
      @(negedge clk);
      c++;
      if (c == 1) check("first_read_advance", read_addr, 1);
    end
    if (hold > 0) check("first_write_latency", c, W + 4);
    i = 0;
    while (done_cnt == d0 && i < 400) begin @(negedge clk); i++; end
    check("frame_done_seen", done_cnt - d0, 1);
    ack_read = 1'b0;
    ack_write = 1'b0;
    repeat (4) @(negedge clk);
    check("frame_done_once", done_cnt - d0, 1);
    check("write_count", wr_cnt, NPIX);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    int i;
    for (int k = 0; k < NPIX; k++) img[k] = 0;

    // Reset state.
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rq_read", rq_read, 0);
    check("rst_rq_write", rq_write, 0);
    check("rst_write_en", write_en, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_read_addr", read_addr, 0);
    check("rst_write_addr", write_addr, 0);
    check("rst_write_data", write_data, 0);
    check("rst_threshold", threshold_val, THR0);
    reset = 1'b1;
    @(negedge clk);

    // Threshold saturation at both ends and up/down tie.
    repeat (300) thr_pulse(1'b0, 1'b1);
    check("thr_floor", threshold_val, model_thr);
    repeat (3) thr_pulse(1'b0, 1'b1);
    check("thr_floor_hold", threshold_val, model_thr);
    thr_pulse(1'b1, 1'b1);
    check("thr_tie_at_zero", threshold_val, model_thr);
    repeat (225) thr_pulse(1'b1, 1'b0);
    check("thr_restore", threshold_val, model_thr);
    thr_pulse(1'b1, 1'b1);
    check("thr_tie", threshold_val, model_thr);
    repeat (2700) thr_pulse(1'b1, 1'b0);
    check("thr_ceiling", threshold_val, model_thr);
    repeat (2700) thr_pulse(1'b0, 1'b1);
    repeat (225) thr_pulse(1'b1, 1'b0);
    check("thr_back_to_init", threshold_val, model_thr);

    // Uniform frame with a read-grant stall.
    for (int k = 0; k < NPIX; k++) img[k] = 1000;
    run_frame(10);

    // Vertical step edge at the default threshold, then at 10000.
    for (int k = 0; k < NPIX; k++) img[k] = (k % W >= 4) ? 4000 : 0;
    run_frame(0);
    repeat (125) thr_pulse(1'b0, 1'b1);
    check("thr_10000", threshold_val, model_thr);
    run_frame(0);

    // Random frames with random threshold moves.
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < NPIX; k++) img[k] = int'($urandom_range(0, 6000));
      repeat ($urandom_range(0, 150)) thr_pulse(1'b1, 1'b0);
      repeat ($urandom_range(0, 100)) thr_pulse(1'b0, 1'b1);
      thr_pulse(1'b1, 1'b1);
      check("thr_random_adjust", threshold_val, model_thr);
      run_frame(0);
    end

    // Reset in the middle of a frame, then a clean frame.
    for (int k = 0; k < NPIX; k++) img[k] = int'($urandom_range(0, 32767));
    repeat (7) thr_pulse(1'b1, 1'b0);
    push_expected();
    i = 0;
    while (!rq_read && i < 50) begin @(negedge clk); i++; end
    ack_read = 1'b1;
    ack_write = 1'b1;
    i = 0;
    while (read_addr != 20 && i < 100) begin @(negedge clk); i++; end
    check("reached_read_20", read_addr, 20);
    reset = 1'b0;
    #1;
    check("abort_rq_read", rq_read, 0);
    check("abort_rq_write", rq_write, 0);
    check("abort_write_en", write_en, 0);
    check("abort_busy", busy, 0);
    check("abort_read_addr", read_addr, 0);
    check("abort_write_addr", write_addr, 0);
    check("abort_write_data", write_data, 0);
    check("abort_threshold", threshold_val, THR0);
    exp_q.delete();
    model_thr = THR0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run_frame(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
